// File: rtl/button_event_arbiter_pkg.sv
// rtl/button_event_arbiter_pkg.sv - shared event definitions and packing helper
package button_event_arbiter_pkg;

  `include "btn_evt_defs.vh"

  // Build an event word: button index in the high nibble, type in the low two bits.
  function automatic logic [EVT_W-1:0] pack_evt(input logic [3:0] btn, input logic [1:0] typ);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_BTN_MSB:EVT_BTN_LSB]   = btn;
    e[EVT_TYPE_MSB:EVT_TYPE_LSB] = typ;
    return e;
  endfunction

endpackage

// File: rtl/btn_evt_defs.vh
// rtl/btn_evt_defs.vh - event type codes and evt_data field layout
`ifndef BTN_EVT_DEFS_VH
`define BTN_EVT_DEFS_VH

localparam int EVT_W = 8;

localparam logic [1:0] EVT_DOWN = 2'd0;
localparam logic [1:0] EVT_UP   = 2'd1;
localparam logic [1:0] EVT_SHRT = 2'd2;
localparam logic [1:0] EVT_LONG = 2'd3;

localparam int EVT_BTN_MSB  = 7;
localparam int EVT_BTN_LSB  = 4;
localparam int EVT_TYPE_MSB = 1;
localparam int EVT_TYPE_LSB = 0;

`endif

// File: rtl/evt_fifo_sync.sv
// rtl/evt_fifo_sync.sv - first-word-fall-through synchronous FIFO with flush and level
module evt_fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [W-1:0]     wr_tdata,
  input  logic             wr_tvalid,
  output logic             wr_tready,
  output logic [W-1:0]     rd_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign full      = (level_q == LVL_W'(DEPTH));
  assign rd_tvalid = (level_q != '0);
  assign do_pop    = rd_tready & rd_tvalid;
  assign wr_tready = ~full | do_pop;
  assign do_push   = wr_tvalid & wr_tready & ~flush;
  assign rd_tdata  = rd_tvalid ? mem[rd_ptr] : '0;
  assign level     = level_q;

  // Pointer and occupancy bookkeeping; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  // Storage array; contents are only observed through the occupancy gate.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_tdata;
  end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - edge capture, round-robin serialisation and event FIFO
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic [NUM_BTN-1:0] btn_down,
  input  logic [NUM_BTN-1:0] btn_up,
  input  logic [NUM_BTN-1:0] btn_shrt,
  input  logic [NUM_BTN-1:0] btn_long,
  output logic [EVT_W-1:0]   evt_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               irq,
  output logic               ovf,
  input  logic               ovf_clr
);

  localparam int NSLOT  = 4 * NUM_BTN;
  localparam int SLOT_W = $clog2(NSLOT);

  logic [NSLOT-1:0]  req;
  logic [NSLOT-1:0]  prev_q;
  logic [NSLOT-1:0]  rise;
  logic [NSLOT-1:0]  pending_q;
  logic [NSLOT-1:0]  grant_oh;
  logic [SLOT_W-1:0] ptr_q;
  logic [SLOT_W-1:0] grant_idx;
  logic              grant_vld;
  logic              init_q;
  logic              wr_ok;
  logic [EVT_W-1:0]  wr_evt;

  // Flatten the four pulse buses into slots ordered btn*4 + type.
  always_comb begin
    req = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      req[b*4 + int'(EVT_DOWN)] = btn_down[b];
      req[b*4 + int'(EVT_UP)]   = btn_up[b];
      req[b*4 + int'(EVT_SHRT)] = btn_shrt[b];
      req[b*4 + int'(EVT_LONG)] = btn_long[b];
    end
  end

  // init_q blanks the first cycle after reset so levels held through reset are not edges.
  assign rise = req & ~prev_q & {NSLOT{en & init_q}};

  // Round-robin search starting just above the last granted slot.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = 1; i <= NSLOT; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NSLOT) idx = idx - NSLOT;
      if (!grant_vld && pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SLOT_W'(idx);
      end
    end
    grant_vld = grant_vld & wr_ok & ~flush;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  assign wr_evt = pack_evt(4'(grant_idx >> 2), grant_idx[1:0]);

  // Edge history, pending requests, round-robin pointer and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      ovf       <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      prev_q <= req;
      init_q <= 1'b1;
      if (flush) pending_q <= '0;
      else       pending_q <= (pending_q & ~grant_oh) | rise;
      if (grant_vld) ptr_q <= grant_idx;
      if (!flush && |(rise & pending_q & ~grant_oh)) ovf <= 1'b1;
      else if (ovf_clr)                              ovf <= 1'b0;
    end
  end

  evt_fifo_sync #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_tdata  (wr_evt),
    .wr_tvalid (grant_vld),
    .wr_tready (wr_ok),
    .rd_tdata  (evt_data),
    .rd_tvalid (evt_valid),
    .rd_tready (evt_ready),
    .level     (fifo_level)
  );

  assign irq = evt_valid;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;

  localparam int NUM_BTN    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               flush;
  logic [NUM_BTN-1:0] btn_down;
  logic [NUM_BTN-1:0] btn_up;
  logic [NUM_BTN-1:0] btn_shrt;
  logic [NUM_BTN-1:0] btn_long;
  logic [7:0]         evt_data;
  logic               evt_valid;
  logic               evt_ready;
  logic [LVL_W-1:0]   fifo_level;
  logic               irq;
  logic               ovf;
  logic               ovf_clr;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  button_event_arbiter #(
    .NUM_BTN    (NUM_BTN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .btn_down   (btn_down),
    .btn_up     (btn_up),
    .btn_shrt   (btn_shrt),
    .btn_long   (btn_long),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .fifo_level (fifo_level),
    .irq        (irq),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] d, input logic [3:0] u,
                         input logic [3:0] s, input logic [3:0] l);
    btn_down = d;
    btn_up   = u;
    btn_shrt = s;
    btn_long = l;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    evt_ready = 1'b0;
    en        = 1'b1;
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || evt_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  // Scoreboard: every accepted pop is compared against the oldest expected event.
  always begin
    @(negedge clk);
    #2;
    if (!rst && evt_valid && evt_ready) begin
      check("sb_has_expect", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("evt_data", 32'(evt_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst       = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    evt_ready = 1'b0;
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_irq",   32'(irq), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_data",  32'(evt_data), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();

    // Single btn_down[2] pulse: two-cycle latency, then pop
    set_btn(4'b0100, 4'h0, 4'h0, 4'h0);
    sb.push_back(8'h20);
    tick();
    check("lat1_valid", 32'(evt_valid), 32'd0);
    tick();
    check("lat2_valid", 32'(evt_valid), 32'd1);
    check("lat2_irq",   32'(irq), 32'd1);
    check("lat2_data",  32'(evt_data), 32'h20);
    check("lat2_level", 32'(fifo_level), 32'd1);
    repeat (8) tick();
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    evt_ready = 1'b1;
    wait_drained(20);
    check("t1_valid_after_pop", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Three simultaneous rises from ptr=0
    do_reset();
    set_btn(4'b0000, 4'b1000, 4'b0001, 4'b0010);
    sb.push_back(8'h02);
    sb.push_back(8'h13);
    sb.push_back(8'h31);
    repeat (3) tick();
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    evt_ready = 1'b1;
    wait_drained(30);
    evt_ready = 1'b0;

    // Ten events into an eight-deep FIFO
    do_reset();
    set_btn(4'b0111, 4'b0111, 4'b0011, 4'b0011);
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
    sb.push_back(8'h13); sb.push_back(8'h20); sb.push_back(8'h21);
    sb.push_back(8'h00);
    repeat (14) tick();
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ovf", 32'(ovf), 32'd0);
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    evt_ready = 1'b1;
    wait_drained(40);
    evt_ready = 1'b0;

    // Overflow on an already-pending slot, clear, and set-wins-over-clear
    do_reset();
    set_btn(4'h0, 4'h0, 4'hF, 4'hF);
    sb.push_back(8'h02); sb.push_back(8'h03); sb.push_back(8'h12);
    sb.push_back(8'h13); sb.push_back(8'h22); sb.push_back(8'h23);
    sb.push_back(8'h32); sb.push_back(8'h33);
    repeat (12) tick();
    check("t4_level_full", 32'(fifo_level), 32'd8);
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    btn_down = 4'b0010;
    sb.push_back(8'h10);
    tick();
    btn_down = 4'b0000;
    tick();
    check("t4_first_pend_no_ovf", 32'(ovf), 32'd0);
    btn_down = 4'b0010;
    tick();
    check("t4_ovf_set", 32'(ovf), 32'd1);
    btn_down = 4'b0000;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'd0);
    btn_down = 4'b0010;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr  = 1'b0;
    btn_down = 4'b0000;
    check("t4_ovf_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr2", 32'(ovf), 32'd0);
    check("t4_full_hold", 32'(fifo_level), 32'd8);

    // Full FIFO, continuous pops and one new event per cycle
    for (int k = 0; k < 6; k++) begin
      btn_up = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      sb.push_back((k % 2 == 0) ? 8'h01 : 8'h11);
      evt_ready = 1'b1;
      tick();
      check("t5_steady_level", 32'(fifo_level), 32'd8);
    end
    btn_up = 4'b0000;
    wait_drained(40);
    evt_ready = 1'b0;

    // Flush with 5 queued and 2 pending plus a concurrent rise
    do_reset();
    set_btn(4'b1100, 4'b1100, 4'b1100, 4'b0100);
    repeat (6) tick();
    check("t6_pre_flush_level", 32'(fifo_level), 32'd5);
    flush  = 1'b1;
    btn_up = 4'b1101;
    tick();
    flush = 1'b0;
    check("t6_flush_level", 32'(fifo_level), 32'd0);
    check("t6_flush_valid", 32'(evt_valid), 32'd0);
    repeat (10) tick();
    check("t6_post_level", 32'(fifo_level), 32'd0);
    check("t6_post_valid", 32'(evt_valid), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    en = 1'b0;
    set_btn(4'hF, 4'hF, 4'hF, 4'hF);
    repeat (2) tick();
    set_btn(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) tick();
    en = 1'b1;
    repeat (5) tick();
    check("t6_en_off_level", 32'(fifo_level), 32'd0);
    check("t6_en_off_valid", 32'(evt_valid), 32'd0);

    // Reset mid-operation with an input held high across it
    btn_down = 4'b0001;
    repeat (3) tick();
    check("t7_pre_rst_level", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    repeat (6) tick();
    check("t7_no_trailing_level", 32'(fifo_level), 32'd0);
    check("t7_no_trailing_valid", 32'(evt_valid), 32'd0);
    btn_down = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
